// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
// Provides the FSM state enum, table-width helper and standard 2-input truth tables.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    // One truth-table bit per input combination.
    function automatic int tt_width(input int n_in);
        return 32'sd1 << n_in;
    endfunction

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
// Also exposes the next-state value so callers can act on the post-edge count.
module gate_chk_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for basic-gate benches: compares sampled gate outputs to a truth table.
// Optional first-mismatch capture is enabled by defining GATE_CHK_FIRST_ERR_EN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int                   N_IN        = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = TT_AND2,
    parameter int                   ERR_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN-1:0]            in_vec,
    input  logic                       in_y,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [tt_width(N_IN)-1:0]  cov_mask,
    output logic [N_IN-1:0]            first_err_vec,
    output logic                       first_err_vld
);

    localparam int TW = tt_width(N_IN);

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [TW-1:0]    cov_q;
    logic [TW-1:0]    cov_d;
    logic             pass_q;
    logic             pass_d;
    logic [ERR_W-1:0] err_cnt_nxt_s;
    logic             accept_s;
    logic             mismatch_s;
    logic             clr_s;
    logic             cov_full_s;

    // Accept qualification; in_vec/in_y are only looked at on an accept so X elsewhere is masked.
    always_comb begin
        accept_s   = in_valid && (state_q == ST_CHECK);
        clr_s      = start && (state_q != ST_CHECK);
        mismatch_s = 1'b0;
        if (accept_s) begin
            mismatch_s = (in_y != TRUTH_TABLE[in_vec]);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Coverage bookkeeping; cov_full_s looks at the post-edge mask so DONE lands on the final accept.
    always_comb begin
        cov_d = cov_q;
        if (clr_s) begin
            cov_d = {TW{1'b0}};
        end else if (accept_s) begin
            cov_d[in_vec] = 1'b1;
        end else begin
            cov_d = cov_q;
        end
        cov_full_s = &cov_d;
    end

    // FSM next state: abort wins over start inside CHECK, start wins outside.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CHECK;
                else       state_d = ST_IDLE;
            end
            ST_CHECK: begin
                if (abort || cov_full_s) state_d = ST_DONE;
                else                     state_d = ST_CHECK;
            end
            ST_DONE: begin
                if (start) state_d = ST_CHECK;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Verdict is latched on entry to DONE and held until the next start.
    always_comb begin
        pass_d = pass_q;
        case (state_q)
            ST_CHECK: begin
                if (abort)           pass_d = 1'b0;
                else if (cov_full_s) pass_d = (err_cnt_nxt_s == {ERR_W{1'b0}});
                else                 pass_d = 1'b0;
            end
            ST_DONE: begin
                if (start) pass_d = 1'b0;
                else       pass_d = pass_q;
            end
            default: pass_d = 1'b0;
        endcase
    end

    // State, coverage and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cov_q   <= {TW{1'b0}};
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cov_q   <= cov_d;
            pass_q  <= pass_d;
        end
    end

    // Status decodes straight from the state register.
    always_comb begin
        in_ready = (state_q == ST_CHECK);
        busy     = (state_q == ST_CHECK);
        done     = (state_q == ST_DONE);
    end

    assign pass     = pass_q;
    assign cov_mask = cov_q;

    gate_chk_sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_s),
        .inc_i     (mismatch_s),
        .cnt_o     (err_cnt),
        .cnt_nxt_o (err_cnt_nxt_s)
    );

`ifdef GATE_CHK_FIRST_ERR_EN
    logic [N_IN-1:0] fe_vec_q;
    logic [N_IN-1:0] fe_vec_d;
    logic            fe_vld_q;
    logic            fe_vld_d;

    // Capture only the first mismatch of a run.
    always_comb begin
        fe_vec_d = fe_vec_q;
        fe_vld_d = fe_vld_q;
        if (clr_s) begin
            fe_vec_d = {N_IN{1'b0}};
            fe_vld_d = 1'b0;
        end else if (mismatch_s && !fe_vld_q) begin
            fe_vec_d = in_vec;
            fe_vld_d = 1'b1;
        end else begin
            fe_vec_d = fe_vec_q;
            fe_vld_d = fe_vld_q;
        end
    end

    // First-mismatch capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_vec_q <= {N_IN{1'b0}};
            fe_vld_q <= 1'b0;
        end else begin
            fe_vec_q <= fe_vec_d;
            fe_vld_q <= fe_vld_d;
        end
    end

    assign first_err_vec = fe_vec_q;
    assign first_err_vld = fe_vld_q;
`else
    assign first_err_vec = {N_IN{1'b0}};
    assign first_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Self-checking bench for gate_resp_checker (default AND table, plus an ERR_W=2 copy).
// Directed scenarios followed by randomized runs against a behavioural model.
module tb_gate_resp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_vec = 2'b00;
    logic       in_y = 1'b0;

    logic       in_ready, busy, done, pass, fe_vld;
    logic [7:0] err_cnt;
    logic [3:0] cov_mask;
    logic [1:0] fe_vec;

    logic       in_ready2, busy2, done2, pass2, fe_vld2;
    logic [1:0] err_cnt2;
    logic [3:0] cov_mask2;
    logic [1:0] fe_vec2;

    int total = 0;
    int bad = 0;

    // Behavioural model: run flag, verdict, unbounded error count and set of seen inputs.
    bit m_busy, m_done, m_pass, m_fe_vld;
    int m_err, m_seen, m_fe_vec;
    localparam int TT = 8;  // AND2: only input 3 gives 1

    always #5 clk = ~clk;

    gate_resp_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_y(in_y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .cov_mask(cov_mask), .first_err_vec(fe_vec), .first_err_vld(fe_vld)
    );

    gate_resp_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready2), .in_vec(in_vec), .in_y(in_y),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .cov_mask(cov_mask2), .first_err_vec(fe_vec2), .first_err_vld(fe_vld2)
    );

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_pass = 0; m_fe_vld = 0;
        m_err = 0; m_seen = 0; m_fe_vec = 0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit v, input int vec, input bit y);
        if (m_busy) begin
            if (v) begin
                if (y != ((TT >> vec) & 1)) begin
                    m_err++;
                    if (!m_fe_vld) begin
                        m_fe_vld = 1;
                        m_fe_vec = vec;
                    end
                end
                m_seen = m_seen | (1 << vec);
            end
            if (a || m_seen == 15) begin
                m_pass = !a && (m_err == 0) && (m_seen == 15);
                m_busy = 0;
                m_done = 1;
            end
        end else if (s) begin
            m_busy = 1; m_done = 0; m_pass = 0; m_fe_vld = 0;
            m_err = 0; m_seen = 0; m_fe_vec = 0;
        end
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit s, input bit a, input bit v, input logic [1:0] vec, input bit y);
        start = s; abort = a; in_valid = v;
        if (v) begin
            in_vec = vec;
            in_y = y;
        end else begin
            in_vec = 2'bxx;
            in_y = 1'bx;
        end
        @(posedge clk);
        model_edge(s, a, v, int'(vec), y);
        @(negedge clk);
        start = 0; abort = 0; in_valid = 0; in_vec = 2'bxx; in_y = 1'bx;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if ({in_ready, busy, done, pass} !== 4'b0000) begin bad++; $display("FAIL reset_flags got %b want 0000", {in_ready, busy, done, pass}); end
        total++; if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_err got %0d/%0d want 0", err_cnt, err_cnt2); end
        total++; if (cov_mask !== 4'd0) begin bad++; $display("FAIL reset_cov got %b want 0000", cov_mask); end
        total++; if (fe_vld !== 1'b0 || fe_vec !== 2'd0) begin bad++; $display("FAIL reset_fe got %b/%b want 0/00", fe_vld, fe_vec); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_garbage();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, (i == 3), 1'b1, 2'($urandom_range(3, 0)), 1'($urandom));
            total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_ready got %b/%b want 0/0", in_ready, busy); end
            total++; if (err_cnt !== 8'd0 || cov_mask !== 4'd0) begin bad++; $display("FAIL idle_state got err=%0d cov=%b want 0/0000", err_cnt, cov_mask); end
        end
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        total++; if (busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL idle_start_abort got busy=%b ready=%b want 1/1", busy, in_ready); end
        // start during CHECK must not clear the run
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        total++; if (cov_mask !== 4'b0011 || busy !== 1'b1) begin bad++; $display("FAIL start_in_check got cov=%b busy=%b want 0011/1", cov_mask, busy); end
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_and_pass();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        total++; if (cov_mask !== 4'd0 || err_cnt !== 8'd0 || done !== 1'b0) begin bad++; $display("FAIL and_clear got cov=%b err=%0d done=%b", cov_mask, err_cnt, done); end
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        total++; if (cov_mask !== 4'b0111 || done !== 1'b0) begin bad++; $display("FAIL and_partial got cov=%b done=%b want 0111/0", cov_mask, done); end
        cycle(1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
        total++; if (done !== 1'b1 || pass !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL and_done got done=%b pass=%b ready=%b want 1/1/0", done, pass, in_ready); end
        total++; if (err_cnt !== 8'd0 || cov_mask !== 4'b1111) begin bad++; $display("FAIL and_final got err=%0d cov=%b want 0/1111", err_cnt, cov_mask); end
    endtask

    task automatic test_or_errors();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
        total++; if (err_cnt !== 8'd2 || pass !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL or_result got err=%0d pass=%b done=%b want 2/0/1", err_cnt, pass, done); end
        total++; if (cov_mask !== 4'b1111) begin bad++; $display("FAIL or_cov got %b want 1111", cov_mask); end
`ifdef GATE_CHK_FIRST_ERR_EN
        total++; if (fe_vec !== 2'b01 || fe_vld !== 1'b1) begin bad++; $display("FAIL or_first_err got %b/%b want 01/1", fe_vec, fe_vld); end
`else
        total++; if (fe_vec !== 2'b00 || fe_vld !== 1'b0) begin bad++; $display("FAIL or_first_err got %b/%b want 00/0", fe_vec, fe_vld); end
`endif
    endtask

    task automatic test_abort();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        total++; if (cov_mask !== 4'b0011 || err_cnt !== 8'd0) begin bad++; $display("FAIL abort_state got cov=%b err=%0d want 0011/0", cov_mask, err_cnt); end
        total++; if (done !== 1'b1 || pass !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL abort_flags got done=%b pass=%b ready=%b want 1/0/0", done, pass, in_ready); end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
            total++; if (err_cnt2 !== 2'((i + 1 > 3) ? 3 : i + 1)) begin bad++; $display("FAIL sat_step%0d got %0d want %0d", i, err_cnt2, (i + 1 > 3) ? 3 : i + 1); end
        end
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        total++; if (err_cnt2 !== 2'd3 || done2 !== 1'b1 || pass2 !== 1'b0) begin bad++; $display("FAIL sat_final got err=%0d done=%b pass=%b want 3/1/0", err_cnt2, done2, pass2); end
        total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide got %0d want 5", err_cnt); end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        in_valid = 1'b1; in_vec = 2'd2; in_y = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({in_ready, busy, done, pass} !== 4'b0000 || err_cnt !== 8'd0 || cov_mask !== 4'd0) begin bad++; $display("FAIL async_reset got flags=%b err=%0d cov=%b want 0000/0/0000", {in_ready, busy, done, pass}, err_cnt, cov_mask); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || cov_mask !== 4'd0) begin bad++; $display("FAIL async_hold got busy=%b cov=%b want 0/0000", busy, cov_mask); end
        rst_n = 1'b1;
        in_valid = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 3; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, 2'(i), (i == 3));
        total++; if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 8'd0) begin bad++; $display("FAIL after_reset_run got done=%b pass=%b err=%0d want 1/1/0", done, pass, err_cnt); end
    endtask

    task automatic test_random();
        bit s, a, v, y, ok;
        logic [1:0] vec;
        for (int i = 0; i < 600; i++) begin
            s   = ($urandom_range(9, 0) == 0);
            a   = ($urandom_range(49, 0) == 0);
            v   = ($urandom_range(3, 0) != 0);
            vec = 2'($urandom_range(3, 0));
            ok  = ($urandom_range(3, 0) != 0);
            y   = ok ? 1'((TT >> vec) & 1) : ~1'((TT >> vec) & 1);
            cycle(s, a, v, vec, y);
            total++; if (in_ready !== m_busy || busy !== m_busy || done !== m_done) begin bad++; $display("FAIL rnd_state cyc%0d got r=%b b=%b d=%b want %b/%b/%b", i, in_ready, busy, done, m_busy, m_busy, m_done); end
            total++; if (pass !== m_pass) begin bad++; $display("FAIL rnd_pass cyc%0d got %b want %b", i, pass, m_pass); end
            total++; if (int'(err_cnt) != ((m_err > 255) ? 255 : m_err)) begin bad++; $display("FAIL rnd_err cyc%0d got %0d want %0d", i, err_cnt, m_err); end
            total++; if (int'(err_cnt2) != ((m_err > 3) ? 3 : m_err)) begin bad++; $display("FAIL rnd_err2 cyc%0d got %0d want %0d", i, err_cnt2, (m_err > 3) ? 3 : m_err); end
            total++; if (int'(cov_mask) != m_seen) begin bad++; $display("FAIL rnd_cov cyc%0d got %b want %0b", i, cov_mask, m_seen); end
`ifdef GATE_CHK_FIRST_ERR_EN
            total++; if (fe_vld !== m_fe_vld || int'(fe_vec) != m_fe_vec) begin bad++; $display("FAIL rnd_fe cyc%0d got %b/%0d want %b/%0d", i, fe_vld, fe_vec, m_fe_vld, m_fe_vec); end
`else
            total++; if (fe_vld !== 1'b0 || fe_vec !== 2'd0) begin bad++; $display("FAIL rnd_fe cyc%0d got %b/%0d want 0/0", i, fe_vld, fe_vec); end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_garbage();
        test_and_pass();
        test_or_errors();
        test_abort();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
